io_bus_arbiter: RTL
===================

# io_bus_arbiter

Shares the single I/O-space bus of `iosystem` (one read address, one byte-enabled 16-bit write port, registered read data) between `NUM_MASTERS` bus masters, typically the CPU and a DMA or debug engine. It runs a registered round-robin grant with an optional per-master bus lock for read-modify-write sequences and a lock-timeout guard. It drives the peripheral-side bus from the current owner and returns read data with a per-master valid strobe.

## Interface
- `NUM_MASTERS`, 2: number of requesters, 2..8.
- `MAX_LOCK`, 16: maximum consecutive LOCKED cycles before forced release; 0 disables the timeout.
- `clk  in  1`: system clock.
- `reset  in  1`: reset, asynchronous and active-low.
- `m_req  in  NUM_MASTERS`: per-master transfer request; held with its address and data until granted.
- `m_lock  in  NUM_MASTERS`: keep ownership after the current transfer.
- `m_read_addr  in  NUM_MASTERS x 16`: per-master read address.
- `m_write_addr  in  NUM_MASTERS x 16`: per-master write address.
- `m_write_data  in  NUM_MASTERS x 16`: per-master write data.
- `m_write_en  in  NUM_MASTERS x 2`: per-master byte write enables.
- `m_gnt  out  NUM_MASTERS`: one-hot grant, registered.
- `m_rvalid  out  NUM_MASTERS`: read data valid for master i, registered.
- `m_read_data  out  16`: broadcast read data (`io_dread_data` passthrough).
- `io_dread_addr  out  16`, `io_dwrite_addr  out  16`, `io_dwrite_data  out  16`, `io_dwrite_en  out  2`: bus to `iosystem`.
- `io_dread_data  in  16`: registered read data from `iosystem`.
- `lock_timeout  out  1`: one-cycle pulse on forced lock release.

## Operation
- State: `owner` index, `rr_ptr` (last winner) and `state` ∈ {IDLE, GRANT, LOCKED}.
- IDLE:
  - `m_gnt`=0 and `io_dwrite_en`=0.
  - If any `m_req` is set, pick the winner round-robin starting at `rr_ptr+1` (mod NUM_MASTERS), set `owner` and `rr_ptr` to it, and go to GRANT.
- Transfer: any cycle with `m_gnt[i] && m_req[i]`.
- Bus mux from `owner`, combinational:
  - `io_dread_addr`, `io_dwrite_addr` and `io_dwrite_data` follow the owner's inputs.
  - `io_dwrite_en` = owner's `m_write_en` only when `state`≠IDLE and `m_req[owner]`; otherwise 0.
- At the end of a GRANT or LOCKED cycle:
  - Owner transferring with `m_lock[owner]`=1 and the timeout not reached → LOCKED, same owner.
  - Otherwise re-arbitrate as in IDLE. The owner is still eligible but ranks last, because `rr_ptr` equals `owner`.
  - No requesters → IDLE.
- Owner drops `m_req` while granted: no transfer occurs; the owner is released at the next edge, even in LOCKED.
- Lock timeout:
  - `lock_cnt` counts consecutive LOCKED cycles and clears on leaving LOCKED.
  - At `lock_cnt`==MAX_LOCK-1, if another master requests: the owner is excluded from this arbitration, `lock_timeout` pulses and the state goes to GRANT for the new winner.
  - If no other master requests, the lock continues and the counter saturates.
- Read return: `m_rvalid[i]` is set the cycle after a transfer by master i. Every transfer is a read; masters ignore unwanted data.
- Simultaneous write and read of the same address: data comes from `iosystem` forwarding; the arbiter adds nothing.

## Timing
- Request to grant: `m_req` rising in cycle t gives `m_gnt` in t+1 at earliest, if uncontended.
- Single uncontended master holding `m_req`: granted every cycle, one transfer per cycle.
- Two masters requesting continuously without lock: grants alternate every cycle.
- Read latency: transfer in cycle t gives `m_rvalid` and `m_read_data` valid in t+1.
- Write: takes effect at the edge ending the transfer cycle.
- Reset asserted, asynchronous:
  - `m_gnt`=0, `m_rvalid`=0, `lock_timeout`=0, `io_dwrite_en`=0, `io_*_addr`/`io_dwrite_data`=0.
  - `state`=IDLE, `owner`=0, `lock_cnt`=0, `rr_ptr`=NUM_MASTERS-1, so master 0 wins the first contention.
- Reset mid-transfer: the write is dropped and no `m_rvalid` is produced.

## Structure
- Package `io_arb_pkg`: `arb_state_t` enum {ARB_IDLE, ARB_GRANT, ARB_LOCKED}, `IO_ADDR_W`=16, `IO_DATA_W`=16.
- Sub-module `rr_pick`: combinational round-robin picker with inputs req vector, start pointer and exclude mask, and outputs index and found. Reused for normal and timeout arbitration.

## Test plan
- Reset, then master 0 holds `m_req` with write 0x00A5 to 0x002A, en=01 → `m_gnt`=01 one cycle later; `io_dwrite_en`=01 with addr 0x002A; `m_rvalid`[0] the following cycle.
- Both masters request continuously without lock → `m_gnt` sequence 01,10,01,10; `io_dwrite_addr` alternates between their addresses.
- Master 1 locked with master 0 requesting, MAX_LOCK=4 → 4 LOCKED cycles, `lock_timeout` pulse, `m_gnt`=01 next.
- Locked master alone for 40 cycles → no `lock_timeout`; grant held throughout.
- Master 0 drops `m_req` while granted with en=11 → `io_dwrite_en`=00 that cycle; released next edge.
- Reset asserted mid-transfer → all outputs 0 immediately; first grant after release goes to master 0 when both request.

Source files
------------

// File: rtl/io_arb_pkg.sv
// Shared types and constants for the io_bus_arbiter codebase slice.
//
// Contents:
//   IO_ADDR_W   - width of I/O-space addresses
//   IO_DATA_W   - width of I/O-space data
//   IO_BE_W     - number of byte write enables on the write port
//   arb_state_t - arbiter state: idle, granted for one transfer, or locked
//   arb_busy()  - true when a master currently owns the bus
package io_arb_pkg;

    localparam int unsigned IO_ADDR_W = 16;
    localparam int unsigned IO_DATA_W = 16;
    localparam int unsigned IO_BE_W   = IO_DATA_W / 8;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT  = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_t;

    function automatic logic arb_busy(input arb_state_t s);
        return s != ARB_IDLE;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//
// Scans the request vector starting at index `start` and wrapping modulo NUM_REQ,
// skipping any requester whose `exclude` bit is set, and returns the first
// eligible index.
//
// Ports:
//   req     in  NUM_REQ  request vector
//   start   in  IDX_W    index that ranks first in this scan
//   exclude in  NUM_REQ  requesters removed from this scan
//   idx     out IDX_W    winning index (0 when nothing found)
//   found   out 1        at least one eligible requester
module rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    input  logic [NUM_REQ-1:0] exclude,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    logic [NUM_REQ-1:0] eligible;
    logic [IDX_W-1:0]   cand;

    assign eligible = req & ~exclude;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(start) + i) % NUM_REQ);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the single iosystem I/O bus between NUM_MASTERS
// bus masters, with an optional per-master bus lock and a lock-timeout guard.
//
// Parameters:
//   NUM_MASTERS  number of requesters, 2..8
//   MAX_LOCK     max consecutive LOCKED cycles before forced release (0: never)
//
// Ports:
//   clk, reset                  clock and asynchronous active-low reset
//   m_req / m_lock              per-master request and lock-after-transfer
//   m_read_addr, m_write_addr   per-master addresses
//   m_write_data, m_write_en    per-master write data and byte enables
//   m_gnt                       one-hot grant (from registered state)
//   m_rvalid                    per-master read valid, registered
//   m_read_data                 broadcast read data (io_dread_data passthrough)
//   io_dread_addr, io_dwrite_*  bus towards iosystem, muxed from the owner
//   io_dread_data               registered read data from iosystem
//   lock_timeout                one-cycle pulse on forced lock release
module io_bus_arbiter
    import io_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned MAX_LOCK    = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_MASTERS-1:0]                m_req,
    input  logic [NUM_MASTERS-1:0]                m_lock,
    input  logic [NUM_MASTERS-1:0][IO_ADDR_W-1:0] m_read_addr,
    input  logic [NUM_MASTERS-1:0][IO_ADDR_W-1:0] m_write_addr,
    input  logic [NUM_MASTERS-1:0][IO_DATA_W-1:0] m_write_data,
    input  logic [NUM_MASTERS-1:0][IO_BE_W-1:0]   m_write_en,
    output logic [NUM_MASTERS-1:0]                m_gnt,
    output logic [NUM_MASTERS-1:0]                m_rvalid,
    output logic [IO_DATA_W-1:0]                  m_read_data,
    output logic [IO_ADDR_W-1:0]                  io_dread_addr,
    output logic [IO_ADDR_W-1:0]                  io_dwrite_addr,
    output logic [IO_DATA_W-1:0]                  io_dwrite_data,
    output logic [IO_BE_W-1:0]                    io_dwrite_en,
    input  logic [IO_DATA_W-1:0]                  io_dread_data,
    output logic                                  lock_timeout
);

    localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
    localparam int unsigned CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    // Counter saturation value; with the timeout disabled it simply parks at all-ones.
    localparam logic [CNT_W-1:0] CNT_SAT =
        CNT_W'((MAX_LOCK == 0) ? ((1 << CNT_W) - 1) : (MAX_LOCK - 1));

    arb_state_t               state_q, state_d;
    logic [IDX_W-1:0]         owner_q, owner_d;
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]         lock_cnt_q, lock_cnt_d;
    logic [NUM_MASTERS-1:0]   rvalid_q, rvalid_d;
    logic                     timeout_q, timeout_d;

    logic                     busy;
    logic [NUM_MASTERS-1:0]   owner_oh;
    logic                     xfer;
    logic                     keep_lock;
    logic                     timeout_at;
    logic                     others_req;
    logic                     force_rel;
    logic [IDX_W-1:0]         start_ptr;
    logic [NUM_MASTERS-1:0]   pick_excl;
    logic [IDX_W-1:0]         pick_idx;
    logic                     pick_found;

    assign busy      = arb_busy(state_q);
    assign owner_oh  = NUM_MASTERS'(1) << owner_q;
    assign xfer      = busy && m_req[owner_q];
    assign keep_lock = xfer && m_lock[owner_q];

    // rr_ptr holds the last winner, so the scan starts one past it.
    assign start_ptr = (rr_ptr_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : rr_ptr_q + 1'b1;

    assign timeout_at = (MAX_LOCK != 0) && (state_q == ARB_LOCKED) && (lock_cnt_q == CNT_SAT);
    assign others_req = |(m_req & ~owner_oh);
    // A lock is only broken when someone else is actually waiting.
    assign force_rel  = keep_lock && timeout_at && others_req;
    assign pick_excl  = force_rel ? owner_oh : '0;

    rr_pick #(
        .NUM_REQ (NUM_MASTERS)
    ) u_rr_pick (
        .req     (m_req),
        .start   (start_ptr),
        .exclude (pick_excl),
        .idx     (pick_idx),
        .found   (pick_found)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        lock_cnt_d = '0;
        timeout_d  = 1'b0;
        rvalid_d   = xfer ? owner_oh : '0;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d  = ARB_GRANT;
                    owner_d  = pick_idx;
                    rr_ptr_d = pick_idx;
                end
            end
            ARB_GRANT, ARB_LOCKED: begin
                if (keep_lock && !force_rel) begin
                    state_d = ARB_LOCKED;
                    // First LOCKED cycle starts from zero; only consecutive cycles count.
                    if (state_q == ARB_LOCKED) begin
                        lock_cnt_d = (lock_cnt_q == CNT_SAT) ? lock_cnt_q : lock_cnt_q + 1'b1;
                    end
                end else if (pick_found) begin
                    state_d   = ARB_GRANT;
                    owner_d   = pick_idx;
                    rr_ptr_d  = pick_idx;
                    timeout_d = force_rel;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= IDX_W'(NUM_MASTERS - 1);
            lock_cnt_q <= '0;
            rvalid_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid_q   <= rvalid_d;
            timeout_q  <= timeout_d;
        end
    end

    // Bus is parked at zero while idle (and therefore throughout reset) so
    // no stale owner address or data is presented to iosystem.
    always_comb begin
        m_gnt          = busy ? owner_oh : '0;
        io_dread_addr  = busy ? m_read_addr[owner_q]  : '0;
        io_dwrite_addr = busy ? m_write_addr[owner_q] : '0;
        io_dwrite_data = busy ? m_write_data[owner_q] : '0;
        io_dwrite_en   = xfer ? m_write_en[owner_q]   : '0;
    end

    assign m_rvalid     = rvalid_q;
    assign m_read_data  = io_dread_data;
    assign lock_timeout = timeout_q;

endmodule
